ps2_key_decoder: RTL and testbench

//  Upstream input stage of the tic-tac-toe controller: receives PS/2 keyboard frames (scan set 2),

---
 rtl/ps2_key_decoder.sv | 177 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-set-2 receiver and key-level decoder for the tic-tac-toe controller.
// Optional build macro PS2_TIMEOUT_EN adds an in-frame idle timeout.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  if (FILTER_LEN < 2) begin : g_bad_filter
    $error("FILTER_LEN must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // index 0 = ps2_clk, index 1 = ps2_data
  logic [1:0]    line_p0, line_p1, flt;
  logic [FW-1:0] flt_cnt [2];
  logic          clk_flt_d;
  logic          fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_p0 <= 2'b11;
      line_p1 <= 2'b11;
    end else begin
      line_p0 <= {ps2_data, ps2_clk};
      line_p1 <= line_p0;
    end
  end

  // Filter: accept a new level only after FILTER_LEN consecutive agreeing samples.
  for (genvar i = 0; i < 2; i++) begin : g_filter
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        flt[i]     <= 1'b1;
        flt_cnt[i] <= '0;
      end else if (line_p1[i] == flt[i]) begin
        flt_cnt[i] <= '0;
      end else if (flt_cnt[i] == FLT_LAST) begin
        flt[i]     <= line_p1[i];
        flt_cnt[i] <= '0;
      end else begin
        flt_cnt[i] <= flt_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_flt_d <= 1'b1;
    else          clk_flt_d <= flt[0];
  end

  assign fall = clk_flt_d & ~flt[0];

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par;
  logic       ext, brk;
  logic       timeout_hit;
  logic       frame_ok;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    to_cnt <= '0;
    else if (fall || state == ST_IDLE) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign frame_ok = flt[1] & (^{shift, par});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      left      <= 1'b0;
      right     <= 1'b0;
      enter     <= 1'b0;
      space     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout_hit) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!flt[1]) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {flt[1], shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= flt[1];
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!frame_ok) begin
              frame_err <= 1'b1;
            end else begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
              if (shift == 8'hE0) begin
                ext <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                // Prefixes apply to exactly one following code, mapped or not.
                case ({ext, shift})
                  9'h05A, 9'h15A: enter <= ~brk;
                  9'h175:         up    <= ~brk;
                  9'h172:         down  <= ~brk;
                  9'h16B:         left  <= ~brk;
                  9'h174:         right <= ~brk;
                  9'h029:         space <= ~brk;
                  default:        ;
                endcase
                ext <= 1'b0;
                brk <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder; define PS2_TIMEOUT_EN to add the timeout scenario.
module tb_ps2_key_decoder;

  localparam int TO_CYC = 300;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, enter, space;
  logic [7:0] rx_byte;
  logic       rx_valid, frame_err;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int ecnt = 0;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .enter(enter), .space(space),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Cycle counts of rx_valid / frame_err high; a clean frame adds exactly 1.
  always @(negedge clk) begin
    if (rx_valid)  vcnt = vcnt + 1;
    if (frame_err) ecnt = ecnt + 1;
  end

  function automatic logic [5:0] keys();
    return {up, down, left, right, enter, space};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ flip);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({keys(), rx_byte, rx_valid, frame_err} !== 16'h0) begin
      bad++; $display("FAIL reset_held outputs=%h want 0", {keys(), rx_byte, rx_valid, frame_err});
    end
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    total++;
    if ({keys(), rx_byte, rx_valid, frame_err} !== 16'h0 || vcnt !== 0 || ecnt !== 0) begin
      bad++; $display("FAIL reset_idle outputs=%h vcnt=%0d ecnt=%0d want 0", {keys(), rx_byte, rx_valid, frame_err}, vcnt, ecnt);
    end
  endtask

  task automatic test_enter();
    int v0;
    v0 = vcnt;
    send_frame(8'h5A, 1'b0, 1'b1);
    total++;
    if (vcnt - v0 !== 1) begin bad++; $display("FAIL enter_valid_cycles got=%0d want=1", vcnt - v0); end
    total++;
    if (rx_byte !== 8'h5A) begin bad++; $display("FAIL enter_rx_byte got=%h want=5a", rx_byte); end
    total++;
    if (keys() !== 6'b000010) begin bad++; $display("FAIL enter_make keys=%b want=000010", keys()); end
    send_frame(8'h5A, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000010) begin bad++; $display("FAIL enter_repeat keys=%b want=000010", keys()); end
    send_frame(8'hF0, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000010) begin bad++; $display("FAIL enter_after_f0 keys=%b want=000010", keys()); end
    send_frame(8'h5A, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000000) begin bad++; $display("FAIL enter_break keys=%b want=000000", keys()); end
  endtask

  task automatic test_arrows();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b100000) begin bad++; $display("FAIL up_make keys=%b want=100000", keys()); end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000000) begin bad++; $display("FAIL up_break keys=%b want=000000", keys()); end
    send_frame(8'h75, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000000 || rx_byte !== 8'h75) begin
      bad++; $display("FAIL lone_75 keys=%b rx=%h want keys=000000 rx=75", keys(), rx_byte);
    end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h72, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b010100) begin bad++; $display("FAIL down_right keys=%b want=010100", keys()); end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h72, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h74, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000000) begin bad++; $display("FAIL arrows_released keys=%b want=000000", keys()); end
  endtask

  task automatic test_combo();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b001001) begin bad++; $display("FAIL left_space keys=%b want=001001", keys()); end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h6B, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000001) begin bad++; $display("FAIL left_break keys=%b want=000001", keys()); end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000000) begin bad++; $display("FAIL space_break keys=%b want=000000", keys()); end
  endtask

  task automatic test_errors();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h29, 1'b1, 1'b1);
    total++;
    if (ecnt - e0 !== 1 || vcnt - v0 !== 0) begin
      bad++; $display("FAIL parity_err err=%0d valid=%0d want err=1 valid=0", ecnt - e0, vcnt - v0);
    end
    total++;
    if (keys() !== 6'b000000) begin bad++; $display("FAIL parity_keys keys=%b want=000000", keys()); end
    v0 = vcnt; e0 = ecnt;
    send_frame(8'h29, 1'b0, 1'b0);
    total++;
    if (ecnt - e0 !== 1 || vcnt - v0 !== 0) begin
      bad++; $display("FAIL stop_err err=%0d valid=%0d want err=1 valid=0", ecnt - e0, vcnt - v0);
    end
    total++;
    if (keys() !== 6'b000000) begin bad++; $display("FAIL stop_keys keys=%b want=000000", keys()); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = vcnt; e0 = ecnt;
    ps2_data = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    @(posedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    total++;
    if (ecnt - e0 !== 0 || vcnt - v0 !== 1 || rx_byte !== 8'h5A) begin
      bad++; $display("FAIL glitch err=%0d valid=%0d rx=%h want err=0 valid=1 rx=5a", ecnt - e0, vcnt - v0, rx_byte);
    end
    total++;
    if (keys() !== 6'b000010) begin bad++; $display("FAIL glitch_keys keys=%b want=000010", keys()); end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    int v0, e0;
    send_frame(8'h29, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000001) begin bad++; $display("FAIL pre_reset_space keys=%b want=000001", keys()); end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    v0 = vcnt; e0 = ecnt;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({keys(), rx_byte, rx_valid, frame_err} !== 16'h0) begin
      bad++; $display("FAIL mid_reset outputs=%h want 0", {keys(), rx_byte, rx_valid, frame_err});
    end
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    total++;
    if (ecnt - e0 !== 0 || vcnt - v0 !== 1 || keys() !== 6'b000010) begin
      bad++; $display("FAIL after_reset err=%0d valid=%0d keys=%b want err=0 valid=1 keys=000010", ecnt - e0, vcnt - v0, keys());
    end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    int v0, e0;
    send_frame(8'hE0, 1'b0, 1'b1);
    v0 = vcnt; e0 = ecnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO_CYC + 60) @(negedge clk);
    total++;
    if (ecnt - e0 !== 1 || vcnt - v0 !== 0) begin
      bad++; $display("FAIL timeout_err err=%0d valid=%0d want err=1 valid=0", ecnt - e0, vcnt - v0);
    end
    send_frame(8'h75, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000000 || rx_byte !== 8'h75) begin
      bad++; $display("FAIL timeout_ext_clear keys=%b rx=%h want keys=000000 rx=75", keys(), rx_byte);
    end
    send_frame(8'h5A, 1'b0, 1'b1);
    total++;
    if (keys() !== 6'b000010 || rx_byte !== 8'h5A) begin
      bad++; $display("FAIL timeout_recover keys=%b rx=%h want keys=000010 rx=5a", keys(), rx_byte);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_enter();
    test_arrows();
    test_combo();
    test_errors();
    test_glitch();
    test_mid_reset();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
